alu_op_sequencer: RTL

- Initiator side of the 8-bit ALU operand/result interface.
- Accepts one operation request at a time on a valid/ready port and drives the ALU operand, select and carry inputs.
- Holds those inputs stable for the ALU's fixed latency, then captures the ALU result into an accumulator and a response port with valid/ready handshake.
- Sits between a control unit and the ALU; optionally chains operations by substituting the accumulator for operand A.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_op_sequencer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Constants, FSM encoding and request bundle shared by the
//               ALU operation sequencer and the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [SEL_W-1:0]  sel;
        logic              c_in;
        logic              use_acc;
    } alu_req_t;

endpackage
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Issues one request at a time to a fixed-latency ALU, captures
//               the result into an accumulator and a valid/ready response.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
    import alu_pkg::ST_IDLE;
    import alu_pkg::ST_WAIT;
    import alu_pkg::ST_RESP;
#(
    parameter int DATA_W      = alu_pkg::DATA_W,
    parameter int SEL_W       = alu_pkg::SEL_W,
    parameter int ALU_LATENCY = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [SEL_W-1:0]  req_sel,
    input  logic              req_c_in,
    input  logic              req_use_acc,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    output logic              alu_c_in,
    input  logic [DATA_W-1:0] alu_y,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_y,
    output logic [DATA_W-1:0] acc_out,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    localparam logic [3:0] c_lat_init = 4'(ALU_LATENCY - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [3:0]        r_lat_cnt;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [SEL_W-1:0]  r_alu_sel;
    logic              r_alu_c_in;
    logic [DATA_W-1:0] r_rsp_y;
    logic [DATA_W-1:0] r_acc;
    logic              r_rsp_valid;
    logic [CNT_W-1:0]  r_op_count;
    logic              w_req_ready;
    logic              w_busy;

    logic w_accept;
    logic w_capture;
    logic w_rsp_done;

    assign w_accept   = (r_state == ST_IDLE) && req_valid;
    assign w_capture  = (r_state == ST_WAIT) && (r_lat_cnt == 4'd0);
    assign w_rsp_done = (r_state == ST_RESP) && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)   w_state_nxt = ST_WAIT;
            ST_WAIT: if (w_capture)  w_state_nxt = ST_RESP;
            ST_RESP: if (w_rsp_done) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_req_ready = 1'b0;
        w_busy      = 1'b1;
        if (r_state == ST_IDLE) begin
            w_req_ready = 1'b1;
            w_busy      = 1'b0;
        end
    end

    // ALU inputs move only on accept so the ALU sees them stable until capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_sel  <= '0;
            r_alu_c_in <= 1'b0;
            r_lat_cnt  <= 4'd0;
        end else if (w_accept) begin
            r_alu_a    <= req_use_acc ? r_acc : req_a;
            r_alu_b    <= req_b;
            r_alu_sel  <= req_sel;
            r_alu_c_in <= req_c_in;
            r_lat_cnt  <= c_lat_init;
        end else if ((r_state == ST_WAIT) && (r_lat_cnt != 4'd0)) begin
            r_lat_cnt  <= r_lat_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_y     <= '0;
            r_acc       <= '0;
            r_rsp_valid <= 1'b0;
            r_op_count  <= '0;
        end else if (w_capture) begin
            r_rsp_y     <= alu_y;
            r_acc       <= alu_y;
            r_rsp_valid <= 1'b1;
        end else if (w_rsp_done) begin
            r_rsp_valid <= 1'b0;
            r_op_count  <= r_op_count + CNT_W'(1);
        end
    end

    assign req_ready = w_req_ready;
    assign busy      = w_busy;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_sel   = r_alu_sel;
    assign alu_c_in  = r_alu_c_in;
    assign rsp_valid = r_rsp_valid;
    assign rsp_y     = r_rsp_y;
    assign acc_out   = r_acc;
    assign op_count  = r_op_count;

endmodule
`default_nettype wire
